eth_frame_builder: RTL



---
 rtl/eth_frame_builder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/eth_frame_builder.sv
// eth_frame_builder: builds one 72-byte Ethernet II frame per accepted start.
// Sequence: 7x preamble, SFD, DST_MAC, SRC_MAC, ETHERTYPE, 32-bit payload,
// zero padding, then the FCS (reflected CRC-32 over bytes 8..67, sent
// inverted, low byte first). Bytes leave over a valid/ready handshake,
// followed by an IFG_CYCLES idle gap during which busy stays high.
// Optional build macro ETH_BYTE_BITREV_EN bit-reverses every output byte
// for an MSB-dibit-first RMII serializer; framing and CRC are unaffected.
module eth_frame_builder #(
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h0012_3456_789A,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int unsigned IFG_CYCLES = 96
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof
);

    localparam int              GW       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(IFG_CYCLES - 1);
    localparam logic [6:0]      LAST_IDX = 7'd71;
    localparam logic [31:0]     CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, GAP} state_t;

    state_t         state_q;
    logic [6:0]     idx_q;
    logic [31:0]    crc_q;
    logic [31:0]    payload_q;
    logic [GW-1:0]  gap_cnt_q;
    logic           busy_q;
    logic           out_valid_q;
    logic           out_sof_q;
    logic           out_eof_q;
    logic [7:0]     out_data_q;

    logic [7:0]     cur_byte;
    logic [6:0]     idx_d;
    logic [31:0]    crc_d;
    logic [7:0]     out_data_d;

    // Natural-order frame byte at position idx; FCS bytes come from the
    // (already frozen) CRC register.
    function automatic logic [7:0] frame_byte(input logic [6:0] idx,
                                              input logic [31:0] payload,
                                              input logic [31:0] crc);
        int          k;
        logic [47:0] sh;
        logic [31:0] w;
        k  = int'(idx);
        sh = '0;
        w  = '0;
        if (k < 7) begin
            return 8'h55;
        end else if (k == 7) begin
            return 8'hD5;
        end else if (k < 14) begin
            sh = DST_MAC >> (8 * (13 - k));
            return sh[7:0];
        end else if (k < 20) begin
            sh = SRC_MAC >> (8 * (19 - k));
            return sh[7:0];
        end else if (k < 22) begin
            sh = {32'h0, ETHERTYPE} >> (8 * (21 - k));
            return sh[7:0];
        end else if (k < 26) begin
            w = payload >> (8 * (25 - k));
            return w[7:0];
        end else if (k < 68) begin
            return 8'h00;
        end else begin
            w = (~crc) >> (8 * (k - 68));
            return w[7:0];
        end
    endfunction

    // Reflected CRC-32 (poly 0x04C11DB7 reversed = 0xEDB88320), LSB first.
    function automatic logic [31:0] crc_update(input logic [31:0] crc,
                                               input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    // Which streaming state a given byte index belongs to.
    function automatic state_t state_for(input logic [6:0] idx);
        if (idx < 7'd8)       return PREAMBLE;
        else if (idx < 7'd22) return HEADER;
        else if (idx < 7'd68) return PAYLOAD;
        else                  return FCS;
    endfunction

    // Line ordering of a byte as handed to the serializer.
    function automatic logic [7:0] wire_order(input logic [7:0] b);
`ifdef ETH_BYTE_BITREV_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
`else
        return b;
`endif
    endfunction

    // Next byte and next CRC, assuming the current byte is accepted.
    always_comb begin
        // NOTE: every output of this block is given a value before any branch, so no latch can be inferred.
        cur_byte   = frame_byte(idx_q, payload_q, crc_q);
        crc_d      = crc_q;
        idx_d      = idx_q + 7'd1;
        if (state_q == HEADER || state_q == PAYLOAD) begin
            crc_d = crc_update(crc_q, cur_byte);
        end
        out_data_d = wire_order(frame_byte(idx_d, payload_q, crc_d));
    end

    // Frame FSM with registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            crc_q       <= CRC_INIT;
            payload_q   <= '0;
            gap_cnt_q   <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= PREAMBLE;
                        payload_q   <= data_in;
                        crc_q       <= CRC_INIT;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_sof_q   <= 1'b1;
                        out_eof_q   <= 1'b0;
                        out_data_q  <= wire_order(8'h55);
                    end
                end
                PREAMBLE, HEADER, PAYLOAD, FCS: begin
                    if (out_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= GAP;
                            idx_q       <= '0;
                            gap_cnt_q   <= '0;
                            out_valid_q <= 1'b0;
                            out_sof_q   <= 1'b0;
                            out_eof_q   <= 1'b0;
                            out_data_q  <= 8'h00;
                        end else begin
                            state_q     <= state_for(idx_d);
                            idx_q       <= idx_d;
                            crc_q       <= crc_d;
                            out_sof_q   <= 1'b0;
                            out_eof_q   <= (idx_d == LAST_IDX);
                            out_data_q  <= out_data_d;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q   <= IDLE;
                        gap_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_data  = out_data_q;

endmodule
